// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one single-cycle ALU among NREQ requesters (grant -> exec -> response).
// Optional build macro ALU_ARB_FIXED_PRIO_EN: requester 0 gets absolute priority, 1..NREQ-1 rotate.
module alu_arbiter #(
    parameter int unsigned N    = 8,
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ*2-1:0] req_op,
    output logic [NREQ-1:0]   req_ready,
    output logic [N-1:0]      alu_a,
    output logic [N-1:0]      alu_b,
    output logic [1:0]        alu_s,
    input  logic [N-1:0]      alu_z,
    input  logic [3:0]        alu_flags,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_z,
    output logic [3:0]        rsp_flags
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  ptr_nxt;
    logic [IDW-1:0]  win_idx;
    logic            win_found;
    logic [NREQ-1:0] grant;
    logic            take;

    logic [N-1:0]    lat_a;
    logic [N-1:0]    lat_b;
    logic [1:0]      lat_op;
    logic [IDW-1:0]  lat_id;
    logic [N-1:0]    rsp_z_q;
    logic [3:0]      rsp_flags_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // The rotating pointer never names requester 0, so it restarts at 1.
    localparam logic [IDW-1:0] PTR_RST = IDW'(1);
`else
    localparam logic [IDW-1:0] PTR_RST = '0;
`endif

    always_comb begin : pick_winner
        int unsigned idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        if (req_valid[0]) begin
            win_found = 1'b1;
        end else begin
            // Wrap NREQ-1 -> 1 so the search stays inside the rotating group.
            for (int unsigned k = 0; k < NREQ - 1; k++) begin
                idx = 32'(rr_ptr) + k;
                if (idx >= NREQ) begin
                    idx = idx - (NREQ - 1);
                end
                if (!win_found && req_valid[IDW'(idx)]) begin
                    win_found = 1'b1;
                    win_idx   = IDW'(idx);
                end
            end
        end
`else
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!win_found && req_valid[IDW'(idx)]) begin
                win_found = 1'b1;
                win_idx   = IDW'(idx);
            end
        end
`endif
    end

    always_comb begin
        ptr_nxt = rr_ptr;
`ifdef ALU_ARB_FIXED_PRIO_EN
        if (win_idx != '0) begin
            ptr_nxt = (32'(win_idx) == NREQ - 1) ? IDW'(1) : win_idx + IDW'(1);
        end
`else
        ptr_nxt = (32'(win_idx) == NREQ - 1) ? '0 : win_idx + IDW'(1);
`endif
    end

    always_comb begin
        grant = '0;
        if (win_found) begin
            grant[win_idx] = 1'b1;
        end
    end

    assign take      = (state == IDLE) && win_found;
    assign req_ready = (rst_n && state == IDLE) ? grant : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr      <= PTR_RST;
            lat_a       <= '0;
            lat_b       <= '0;
            lat_op      <= '0;
            lat_id      <= '0;
            rsp_z_q     <= '0;
            rsp_flags_q <= '0;
        end else begin
            if (take) begin
                lat_a  <= req_a[32'(win_idx) * N +: N];
                lat_b  <= req_b[32'(win_idx) * N +: N];
                lat_op <= req_op[32'(win_idx) * 2 +: 2];
                lat_id <= win_idx;
                rr_ptr <= ptr_nxt;
            end
            if (state == EXEC) begin
                rsp_z_q     <= alu_z;
                rsp_flags_q <= alu_flags;
            end
        end
    end

    // ALU inputs come straight from the latches so they stay quiet outside EXEC.
    assign alu_a     = lat_a;
    assign alu_b     = lat_b;
    assign alu_s     = lat_op;
    assign rsp_valid = (state == RESP);
    assign rsp_id    = lat_id;
    assign rsp_z     = rsp_z_q;
    assign rsp_flags = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vectors, corner sequences and a random run
// checked against a transaction-level model of the arbitration rules.
module tb_alu_arbiter;

    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam int PTR0 = 1;
`else
    localparam int PTR0 = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ*2-1:0] req_op;
    logic [NREQ-1:0]   req_ready;
    logic [N-1:0]      alu_a;
    logic [N-1:0]      alu_b;
    logic [1:0]        alu_s;
    logic [N-1:0]      alu_z;
    logic [3:0]        alu_flags;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_z;
    logic [3:0]        rsp_flags;

    int checks   = 0;
    int failures = 0;
    bit mon_on   = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .req_ready (req_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_z     (alu_z),
        .alu_flags (alu_flags),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_z     (rsp_z),
        .rsp_flags (rsp_flags)
    );

    // Shared ALU: flags = {N, Z, C, V}; C is carry for add, borrow for sub.
    function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
        logic [8:0] sum;
        logic [7:0] z;
        logic       c;
        logic       v;
        sum = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (s)
            2'b00: begin
                sum = {1'b0, a} + {1'b0, b};
                z   = sum[7:0];
                c   = sum[8];
                v   = (a[7] == b[7]) && (z[7] != a[7]);
            end
            2'b01: begin
                z = a - b;
                c = (a < b);
                v = (a[7] != b[7]) && (z[7] != a[7]);
            end
            2'b10:   z = a & b;
            default: z = a | b;
        endcase
        return {z, z[7], (z == 8'h00), c, v};
    endfunction

    always_comb {alu_z, alu_flags} = alu_fn(alu_a, alu_b, alu_s);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=no-grant required=grant", name);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // ---------------- reference model ----------------
    function automatic int model_winner(input logic [3:0] v, input int ptr);
`ifdef ALU_ARB_FIXED_PRIO_EN
        if (v[0]) return 0;
        for (int k = 0; k < NREQ - 1; k++) begin
            int j;
            j = 1 + ((ptr - 1 + k) % (NREQ - 1));
            if (((v >> j) & 4'd1) != 4'd0) return j;
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (ptr + k) % NREQ;
            if (((v >> j) & 4'd1) != 4'd0) return j;
        end
`endif
        return -1;
    endfunction

    function automatic int model_next_ptr(input int w, input int ptr);
`ifdef ALU_ARB_FIXED_PRIO_EN
        return (w == 0) ? ptr : (w % (NREQ - 1)) + 1;
`else
        return (ptr * 0) + ((w + 1) % NREQ);
`endif
    endfunction

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [1:0] id;
        logic [7:0] z;
        logic [3:0] fl;
    } txn_t;

    int   m_ptr  = PTR0;
    int   m_age  = 0;
    bit   m_busy = 1'b0;
    txn_t m_txn;

    always @(negedge clk) begin
        if (mon_on) begin
            int          w;
            logic [3:0]  exp_rdy;
            logic [11:0] r;
            w       = (rst_n && !m_busy) ? model_winner(req_valid, m_ptr) : -1;
            exp_rdy = (w >= 0) ? 4'(1 << w) : 4'b0000;
            chk("mon_req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("mon_rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age >= 2));
            if (m_busy && m_age >= 2) begin
                chk("mon_rsp_id", 32'(rsp_id), 32'(m_txn.id));
                chk("mon_rsp_z", 32'(rsp_z), 32'(m_txn.z));
                chk("mon_rsp_flags", 32'(rsp_flags), 32'(m_txn.fl));
            end
            if (m_busy && m_age == 1) begin
                chk("mon_alu_a", 32'(alu_a), 32'(m_txn.a));
                chk("mon_alu_b", 32'(alu_b), 32'(m_txn.b));
                chk("mon_alu_s", 32'(alu_s), 32'(m_txn.op));
            end
            if (!rst_n) begin
                m_busy = 1'b0;
                m_age  = 0;
                m_ptr  = PTR0;
            end else if (w >= 0) begin
                m_txn.a  = 8'(req_a >> (w * N));
                m_txn.b  = 8'(req_b >> (w * N));
                m_txn.op = 2'(req_op >> (w * 2));
                m_txn.id = 2'(w);
                r        = alu_fn(m_txn.a, m_txn.b, m_txn.op);
                m_txn.z  = r[11:4];
                m_txn.fl = r[3:0];
                m_busy   = 1'b1;
                m_age    = 1;
                m_ptr    = model_next_ptr(w, m_ptr);
            end else if (m_busy) begin
                if (m_age >= 2) begin
                    if (rsp_ready) m_busy = 1'b0;
                end else begin
                    m_age++;
                end
            end
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [3:0] mask;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [1:0] id;
        logic [7:0] z;
        logic [3:0] fl;
    } vec_t;

    vec_t vt[8];

    function automatic int fair_id(input int k);
`ifdef ALU_ARB_FIXED_PRIO_EN
        return k * 0;
`else
        return k % NREQ;
`endif
    endfunction

    initial begin
        int         gid[5];
        int         gcy[5];
        int         ng;
        bit         got;
        logic [3:0] t4_next;

        //        mask     a      b      op     id     z      {N,Z,C,V}
        vt[0] = '{4'b0010, 8'h7F, 8'h01, 2'b00, 2'd1, 8'h80, 4'b1001};
        vt[1] = '{4'b0100, 8'h05, 8'h05, 2'b01, 2'd2, 8'h00, 4'b0100};
        vt[2] = '{4'b1000, 8'hF0, 8'h3C, 2'b10, 2'd3, 8'h30, 4'b0000};
        vt[3] = '{4'b0001, 8'hA0, 8'h05, 2'b11, 2'd0, 8'hA5, 4'b1000};
        vt[4] = '{4'b0001, 8'hFF, 8'h01, 2'b00, 2'd0, 8'h00, 4'b0110};
        vt[5] = '{4'b0100, 8'h80, 8'h01, 2'b01, 2'd2, 8'h7F, 4'b0001};
        vt[6] = '{4'b0010, 8'h00, 8'h01, 2'b01, 2'd1, 8'hFF, 4'b1010};
        vt[7] = '{4'b1000, 8'h0F, 8'hF0, 2'b10, 2'd3, 8'h00, 4'b0100};
`ifdef ALU_ARB_FIXED_PRIO_EN
        t4_next = 4'b0001;
`else
        t4_next = 4'b1000;
`endif

        // T1: reset with every requester asserting
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        cyc();
        mon_on = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_req_ready", 32'(req_ready), 32'h0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("rst_rsp_z", 32'(rsp_z), 32'h0);
            chk("rst_rsp_flags", 32'(rsp_flags), 32'h0);
            chk("rst_rsp_id", 32'(rsp_id), 32'h0);
            cyc();
        end

        // T3: release with all valid; grants rotate every 3 cycles
        rst_n = 1'b1;
        ng    = 0;
        for (int c = 0; c < 13; c++) begin
            #1;
            if (req_ready != '0 && ng < 5) begin
                for (int j = 0; j < NREQ; j++) begin
                    if (((req_ready >> j) & 4'd1) != 4'd0) gid[ng] = j;
                end
                gcy[ng] = c;
                ng++;
            end
            cyc();
        end
        chk("fair_count", 32'(ng), 32'd5);
        for (int k = 0; k < 5 && k < ng; k++) begin
            chk("fair_id", 32'(gid[k]), 32'(fair_id(k)));
            chk("fair_cycle", 32'(gcy[k]), 32'(3 * k));
        end
        req_valid = '0;
        repeat (3) cyc();

        // Table-driven single-requester transactions (T2 is vt[0])
        for (int i = 0; i < 8; i++) begin
            req_valid = vt[i].mask;
            req_a     = {NREQ{vt[i].a}};
            req_b     = {NREQ{vt[i].b}};
            req_op    = {NREQ{vt[i].op}};
            rsp_ready = 1'b1;
            got       = 1'b0;
            for (int t = 0; t < 8 && !got; t++) begin
                #1;
                if (req_ready != '0) got = 1'b1;
                else cyc();
            end
            if (!got) begin
                timeout("vec_grant_timeout");
                req_valid = '0;
                repeat (4) cyc();
            end else begin
                chk("vec_grant", 32'(req_ready), 32'(vt[i].mask));
                cyc();
                req_valid = '0;
                #1;
                chk("vec_exec_no_grant", 32'(req_ready), 32'h0);
                chk("vec_exec_no_rsp", 32'(rsp_valid), 32'h0);
                cyc();
                #1;
                chk("vec_rsp_valid", 32'(rsp_valid), 32'h1);
                chk("vec_rsp_id", 32'(rsp_id), 32'(vt[i].id));
                chk("vec_rsp_z", 32'(rsp_z), 32'(vt[i].z));
                chk("vec_rsp_flags", 32'(rsp_flags), 32'(vt[i].fl));
                cyc();
            end
        end

        // T4: backpressure holds the response and blocks new grants
        req_valid = 4'b0100;
        req_a     = {NREQ{8'h05}};
        req_b     = {NREQ{8'h05}};
        req_op    = {NREQ{2'b01}};
        rsp_ready = 1'b0;
        #1;
        chk("bp_grant", 32'(req_ready), 32'h4);
        cyc();
        req_valid = '1;
        #1;
        chk("bp_exec_no_grant", 32'(req_ready), 32'h0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_z", 32'(rsp_z), 32'h0);
            chk("bp_flags", 32'(rsp_flags), 32'h4);
            chk("bp_id", 32'(rsp_id), 32'h2);
            chk("bp_no_grant", 32'(req_ready), 32'h0);
            cyc();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_valid_at_accept", 32'(rsp_valid), 32'h1);
        cyc();
        #1;
        chk("bp_back_idle", 32'(rsp_valid), 32'h0);
        chk("bp_next_grant", 32'(req_ready), 32'(t4_next));
        req_valid = '0;
        cyc();

        // T5: reset during EXEC discards the response and rewinds the pointer
        req_valid = 4'b0010;
        #1;
        chk("mid_rst_grant", 32'(req_ready), 32'h2);
        cyc();
        rst_n     = 1'b0;
        req_valid = '0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("mid_rst_no_rsp", 32'(rsp_valid), 32'h0);
            cyc();
        end
        req_valid = '1;
        #1;
        chk("mid_rst_ptr0", 32'(req_ready), 32'h1);
        req_valid = '0;
        cyc();

        // Randomized traffic, including occasional resets, checked by the model
        for (int i = 0; i < 800; i++) begin
            rst_n     = ($urandom_range(99) != 0);
            req_valid = 4'($urandom);
            req_a     = $urandom;
            req_b     = $urandom;
            req_op    = 8'($urandom);
            rsp_ready = ($urandom_range(3) != 0);
            cyc();
        end
        rst_n     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) cyc();

`ifdef ALU_ARB_FIXED_PRIO_EN
        // T6: requester 0 starves requester 2 until it drops
        begin
            int n0;
            int n2;
            n0        = 0;
            n2        = 0;
            req_valid = 4'b0101;
            for (int c = 0; c < 15; c++) begin
                #1;
                if (req_ready == 4'b0001) n0++;
                if (req_ready == 4'b0100) n2++;
                cyc();
            end
            chk("prio_req0_grants", 32'(n0), 32'd5);
            chk("prio_req2_starved", 32'(n2), 32'd0);
            req_valid = 4'b0100;
            got       = 1'b0;
            for (int t = 0; t < 6 && !got; t++) begin
                #1;
                if (req_ready != '0) got = 1'b1;
                else cyc();
            end
            if (!got) timeout("prio_req2_timeout");
            else chk("prio_req2_grant", 32'(req_ready), 32'h4);
            req_valid = '0;
            repeat (4) cyc();
        end
`endif

        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
